mio_bus_responder: RTL

- Responder (slave) side of the CPU memory/IO bus driven by the single-cycle CPU's Addr_out, Data_out, mem_w and CPU_MIO outputs.
- Decodes each request to either an internal word RAM or a small IO register file: LED register, switch input, free-running counter.
- Returns read data and the MIO_ready handshake.
- RAM accesses take a programmable number of wait states; IO accesses complete with minimum latency.

---
 rtl/mio_bus_responder.sv | 115 +++++++++++
 1 files changed

// File: rtl/mio_bus_responder.sv
// Bus responder for the single-cycle CPU: decodes each request to a word RAM or
// to IO registers (LEDs, switches, counter) and acknowledges it with MIO_ready.
module mio_bus_responder #(
    parameter int RAM_AW   = 10,
    parameter int RAM_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_w,
    input  logic        cpu_mio,
    output logic [31:0] rdata,
    output logic        mio_ready,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out
);

    localparam int WW = (RAM_WAIT > 1) ? $clog2(RAM_WAIT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t              state, state_nxt;
    logic [WW-1:0]       wait_cnt, wait_cnt_nxt;
    logic [31:0]         mem [0:(1 << RAM_AW) - 1];
    logic [31:0]         counter;
    logic [31:0]         read_val;
    logic [15:0]         sw_meta, sw_sync;
    logic [RAM_AW-1:0]   ram_idx;
    logic                is_io, sel_sw, sel_cnt, commit;

    assign is_io     = (addr[31:28] == 4'hF);
    assign sel_sw    = is_io && (addr[27:0] == 28'h000_0000);
    assign sel_cnt   = is_io && (addr[27:0] == 28'h000_0004);
    assign ram_idx   = addr[RAM_AW+1:2];
    assign commit    = (state == ACK) && mem_w;
    assign mio_ready = (state == ACK);

    // RAM requests wait RAM_WAIT cycles; dropping cpu_mio while waiting aborts.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                if (cpu_mio) begin
                    if (is_io || RAM_WAIT == 0) begin
                        state_nxt = ACK;
                    end else begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = WW'(RAM_WAIT - 1);
                    end
                end
            end
            WAIT: begin
                if (!cpu_mio) begin
                    state_nxt = IDLE;
                end else if (wait_cnt == '0) begin
                    state_nxt = ACK;
                end else begin
                    wait_cnt_nxt = wait_cnt - 1'b1;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        read_val = 32'h0;
        if (!is_io) begin
            read_val = mem[ram_idx];
        end else if (sel_sw) begin
            read_val = {16'h0, sw_sync};
        end else if (sel_cnt) begin
            read_val = counter;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            rdata    <= 32'h0;
            led_out  <= 16'h0;
            counter  <= 32'h0;
            sw_meta  <= 16'h0;
            sw_sync  <= 16'h0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            sw_meta  <= sw_in;
            sw_sync  <= sw_meta;
            if (state != ACK && state_nxt == ACK) begin
                rdata <= read_val;
            end
            if (commit && sel_sw) begin
                led_out <= wdata[15:0];
            end
            // A counter write overrides that cycle's increment.
            if (commit && sel_cnt) begin
                counter <= wdata;
            end else begin
                counter <= counter + 32'd1;
            end
        end
    end

    // RAM contents deliberately survive reset; reset forces IDLE, so no commit.
    always_ff @(posedge clk) begin
        if (commit && !is_io) begin
            mem[ram_idx] <= wdata;
        end
    end

endmodule
